// File: rtl/iir_pkg.sv
// Shared definitions for the biquad cascade: tap indices, FSM states and
// the rounding/saturation helper used at each section write-back.
package iir_pkg;

  localparam int TAPS   = 5;
  localparam int WIDE_W = 128;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Coefficient value 1.0 in the chosen fixed-point format.
  function automatic logic signed [WIDE_W-1:0] coef_identity(input int frac);
    return 128'sd1 <<< frac;
  endfunction

  localparam logic signed [WIDE_W-1:0] COEF_IDENTITY = coef_identity(20);

  // Round half up, arithmetic shift by frac, clamp to a data_w-bit signed range.
  function automatic logic signed [WIDE_W-1:0] round_sat(
    input  logic signed [WIDE_W-1:0] acc,
    input  int                       frac,
    input  int                       data_w,
    output logic                     sat
  );
    logic signed [WIDE_W-1:0] half;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    logic signed [WIDE_W-1:0] r;
    half = (frac > 0) ? (128'sd1 <<< (frac - 1)) : 128'sd0;
    hi   = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    lo   = -(128'sd1 <<< (data_w - 1));
    r    = (acc + half) >>> frac;
    if (r > hi) begin
      sat = 1'b1;
      r   = hi;
    end else if (r < lo) begin
      sat = 1'b1;
      r   = lo;
    end else begin
      sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared signed multiply-accumulate: acc +/- coef*data per enabled cycle,
// with a synchronous clear that takes priority over accumulation.
module iir_mac #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int ACC_W  = 72
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     sub_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PROD_W = COEF_W + DATA_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // Product, sign extension and next accumulator value.
  always_comb begin
    prod_s     = coef_i * data_i;
    prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    if (clr_i) begin
      acc_d = {ACC_W{1'b0}};
    end else if (en_i) begin
      acc_d = sub_i ? (acc_q - prod_ext_s) : (acc_q + prod_ext_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of NSEC Direct Form I biquads sharing one MAC, one tap per cycle,
// with runtime-programmable coefficients and valid/ready on both sides.
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int FRAC   = 20,
  parameter int NSEC   = 4,
  parameter int ACC_W  = 72
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_W-1:0]      out_data,
  input  logic                          coef_we,
  input  logic [$clog2(NSEC*5)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]      coef_wdata,
  output logic                          coef_ready,
  input  logic                          clear_state,
  output logic                          sat_sticky
);

  localparam int NCOEF  = NSEC * TAPS;
  localparam int ADDR_W = $clog2(NCOEF);
  localparam int SEC_W  = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(coef_identity(FRAC));

  state_e                   state_q, state_d;
  logic [SEC_W-1:0]         sec_q;
  logic [2:0]               tap_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;
  logic                     sat_sticky_q;
  logic                     clear_pend_q;

  logic signed [COEF_W-1:0] coef_q [NCOEF];
  logic signed [DATA_W-1:0] x1_q [NSEC];
  logic signed [DATA_W-1:0] x2_q [NSEC];
  logic signed [DATA_W-1:0] y1_q [NSEC];
  logic signed [DATA_W-1:0] y2_q [NSEC];

  logic                     accept_s, clear_now_s, mac_en_s, mac_clr_s, mac_sub_s;
  logic                     wb_s, last_sec_s, coef_wr_s;
  logic [ADDR_W-1:0]        coef_idx_s;
  logic signed [COEF_W-1:0] coef_rd_s;
  logic signed [DATA_W-1:0] operand_s;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [WIDE_W-1:0] acc_wide_s, y_wide_s;
  logic signed [DATA_W-1:0] y_s;
  logic                     y_sat_s;

  // Next-state and control strobes.
  always_comb begin
    state_d     = state_q;
    accept_s    = 1'b0;
    clear_now_s = 1'b0;
    mac_en_s    = 1'b0;
    mac_clr_s   = 1'b0;
    wb_s        = (state_q == ST_WB);
    last_sec_s  = (sec_q == SEC_W'(NSEC - 1));
    mac_sub_s   = (tap_q >= TAP_A1);
    coef_wr_s   = (state_q == ST_IDLE) && coef_we && (int'(coef_addr) < NCOEF);
    case (state_q)
      ST_IDLE: begin
        // A clear blocks acceptance so the new sample sees zeroed history.
        if (clear_state) begin
          clear_now_s = 1'b1;
        end else if (in_valid) begin
          accept_s  = 1'b1;
          mac_clr_s = 1'b1;
          state_d   = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        mac_en_s = 1'b1;
        if (tap_q == TAP_A2) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_WB: begin
        mac_clr_s = 1'b1;
        if (last_sec_s) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          clear_now_s = clear_pend_q | clear_state;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Coefficient fetch and operand select for the current tap.
  always_comb begin
    coef_idx_s = ADDR_W'(int'(sec_q) * TAPS + int'(tap_q));
    coef_rd_s  = coef_q[coef_idx_s];
    case (tap_q)
      TAP_B0:  operand_s = x_q;
      TAP_B1:  operand_s = x1_q[sec_q];
      TAP_B2:  operand_s = x2_q[sec_q];
      TAP_A1:  operand_s = y1_q[sec_q];
      TAP_A2:  operand_s = y2_q[sec_q];
      default: operand_s = x_q;
    endcase
  end

  iir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (mac_clr_s),
    .en_i    (mac_en_s),
    .sub_i   (mac_sub_s),
    .coef_i  (coef_rd_s),
    .data_i  (operand_s),
    .acc_o   (acc_s)
  );

  // Section output from the completed accumulator.
  always_comb begin
    acc_wide_s = {{(WIDE_W-ACC_W){acc_s[ACC_W-1]}}, acc_s};
    y_wide_s   = round_sat(acc_wide_s, FRAC, DATA_W, y_sat_s);
    y_s        = y_wide_s[DATA_W-1:0];
  end

  // Coefficient RAM, identity after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= ((i % TAPS) == 0) ? COEF_ONE : {COEF_W{1'b0}};
      end
    end else if (coef_wr_s) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  // Per-section history: shifted at write-back, zeroed by clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSEC; s++) begin
        x1_q[s] <= {DATA_W{1'b0}};
        x2_q[s] <= {DATA_W{1'b0}};
        y1_q[s] <= {DATA_W{1'b0}};
        y2_q[s] <= {DATA_W{1'b0}};
      end
    end else if (clear_now_s) begin
      for (int s = 0; s < NSEC; s++) begin
        x1_q[s] <= {DATA_W{1'b0}};
        x2_q[s] <= {DATA_W{1'b0}};
        y1_q[s] <= {DATA_W{1'b0}};
        y2_q[s] <= {DATA_W{1'b0}};
      end
    end else if (wb_s) begin
      x2_q[sec_q] <= x1_q[sec_q];
      x1_q[sec_q] <= x_q;
      y2_q[sec_q] <= y1_q[sec_q];
      y1_q[sec_q] <= y_s;
    end
  end

  // Sequencing, output register and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q        <= {SEC_W{1'b0}};
      tap_q        <= TAP_B0;
      x_q          <= {DATA_W{1'b0}};
      out_data_q   <= {DATA_W{1'b0}};
      out_valid_q  <= 1'b0;
      sat_sticky_q <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      if (accept_s) begin
        x_q   <= in_data;
        sec_q <= {SEC_W{1'b0}};
        tap_q <= TAP_B0;
      end else if (mac_en_s) begin
        tap_q <= (tap_q == TAP_A2) ? TAP_B0 : (tap_q + 3'd1);
      end else if (wb_s && !last_sec_s) begin
        sec_q <= sec_q + SEC_W'(1);
        x_q   <= y_s;
      end

      if (wb_s && last_sec_s) begin
        out_data_q  <= y_s;
        out_valid_q <= 1'b1;
      end else if ((state_q == ST_OUT) && out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (clear_now_s) begin
        clear_pend_q <= 1'b0;
      end else if (clear_state && (state_q != ST_IDLE)) begin
        clear_pend_q <= 1'b1;
      end

      if (clear_now_s) begin
        sat_sticky_q <= 1'b0;
      end else if (wb_s && y_sat_s) begin
        sat_sticky_q <= 1'b1;
      end
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign coef_ready = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for iir_biquad_cascade (NSEC=4, FRAC=20) with hand-computed
// expected outputs for identity, scaling, recursion, saturation, stall and reset.
module tb_iir_biquad_cascade;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_data = 32'sd0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [31:0] out_data;
  logic               coef_we = 1'b0;
  logic [4:0]         coef_addr = 5'd0;
  logic signed [31:0] coef_wdata = 32'sd0;
  logic               coef_ready;
  logic               clear_state = 1'b0;
  logic               sat_sticky;

  int checks = 0;
  int errors = 0;

  iir_biquad_cascade dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_ready  (coef_ready),
    .clear_state (clear_state),
    .sat_sticky  (sat_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [4:0] addr, input logic signed [31:0] val);
    coef_we    = 1'b1;
    coef_addr  = addr;
    coef_wdata = val;
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
  endtask

  // Offer one sample (optionally with a same-cycle coef write), wait for the result, consume it.
  task automatic send(input logic signed [31:0] d, input logic we, input logic [4:0] addr,
                      input logic signed [31:0] wd, output logic signed [31:0] y,
                      output int lat, output logic busy_ok);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    in_valid   = 1'b1;
    in_data    = d;
    coef_we    = we;
    coef_addr  = addr;
    coef_wdata = wd;
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    y = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] y;
    int                 lat;
    logic               busy_ok;
    logic               ok;
    int                 wait_n;
    logic signed [31:0] rec_exp [4];
    logic signed [31:0] rec_in  [4];

    rec_in[0]  = 32'sd1000; rec_in[1]  = 32'sd0;   rec_in[2]  = 32'sd0;   rec_in[3]  = 32'sd0;
    rec_exp[0] = 32'sd1000; rec_exp[1] = 32'sd500; rec_exp[2] = 32'sd250; rec_exp[3] = 32'sd125;

    repeat (3) tick();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat", sat_sticky, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_coef_ready", coef_ready, 1);

    // Default identity coefficients.
    send(32'sd12345, 1'b0, 5'd0, 32'sd0, y, lat, busy_ok);
    check("ident_data", y, 12345);
    check("ident_latency", lat, 24);
    check("ident_busy_in_ready", busy_ok, 1);

    // Sec0 b0=0.5 written in the accepting cycle, then round half up on -3.
    send(32'sd1000, 1'b1, 5'd0, 32'sd524288, y, lat, busy_ok);
    check("half_1000", y, 500);
    check("half_1000_lat", lat, 24);
    send(-32'sd3, 1'b0, 5'd0, 32'sd0, y, lat, busy_ok);
    check("half_m3", y, -1);

    // y = x + 0.5*y1 in sec0.
    write_coef(5'd0, 32'sd1048576);
    write_coef(5'd3, -32'sd524288);
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      send(rec_in[i], 1'b0, 5'd0, 32'sd0, y, lat, busy_ok);
      check($sformatf("recur_%0d", i), y, rec_exp[i]);
    end
    clear_state = 1'b1;
    in_valid    = 1'b1;
    in_data     = 32'sd0;
    tick();
    clear_state = 1'b0;
    in_valid    = 1'b0;
    check("clear_blocks_accept", in_ready, 1);
    send(32'sd0, 1'b0, 5'd0, 32'sd0, y, lat, busy_ok);
    check("recur_after_clear", y, 0);

    // Gain 4 in every section saturates positive.
    write_coef(5'd3, 32'sd0);
    for (int s = 0; s < 4; s++) write_coef(5'(s * 5), 32'sd4194304);
    send(32'sd268435456, 1'b0, 5'd0, 32'sd0, y, lat, busy_ok);
    check("sat_data", y, 2147483647);
    check("sat_sticky_set", sat_sticky, 1);
    pulse_clear();
    check("sat_sticky_clr", sat_sticky, 0);

    // Output stall with blocked sample and dropped coef write.
    for (int s = 0; s < 4; s++) write_coef(5'(s * 5), 32'sd1048576);
    in_valid = 1'b1;
    in_data  = 32'sd42;
    tick();
    in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 200) begin
      tick();
      wait_n++;
    end
    check("stall_latency", wait_n, 24);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid   = 1'b1;
      in_data    = 32'sd99;
      coef_we    = 1'b1;
      coef_addr  = 5'd0;
      coef_wdata = 32'sd524288;
      if (out_data !== 32'sd42 || in_ready !== 1'b0 || out_valid !== 1'b1 || coef_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    check("stall_stable", ok, 1);
    check("stall_data", out_data, 42);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_stall_in_ready", in_ready, 1);
    check("post_stall_out_valid", out_valid, 0);
    send(32'sd1000, 1'b0, 5'd0, 32'sd0, y, lat, busy_ok);
    check("busy_coef_dropped", y, 1000);

    // Reset mid-computation restores identity coefficients and drops the sample.
    write_coef(5'd0, 32'sd524288);
    in_valid = 1'b1;
    in_data  = 32'sd555;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    check("reset_abort_no_output", ok, 1);
    send(32'sd777, 1'b0, 5'd0, 32'sd0, y, lat, busy_ok);
    check("reset_then_777", y, 777);
    check("reset_then_777_lat", lat, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
